// File: rtl/cluster_clock_gate_ctrl_pkg.sv
// Shared types for the cluster clock-gate sequencer: FSM state encoding,
// default sizing, and the per-state output decode.
package cluster_cg_pkg;

    localparam int CG_CNT_WIDTH   = 8;
    localparam int CG_WAKE_CYCLES = 2;

    typedef enum logic [2:0] {
        ST_RUN     = 3'd0,
        ST_DRAIN   = 3'd1,
        ST_QUIESCE = 3'd2,
        ST_GATED   = 3'd3,
        ST_WAKE    = 3'd4
    } cg_state_e;

    function automatic logic st_clk_en(cg_state_e s);
        return (s != ST_GATED);
    endfunction

    function automatic logic st_ack(cg_state_e s);
        return (s == ST_GATED) || (s == ST_WAKE);
    endfunction

endpackage

// File: rtl/cluster_clock_gate_ctrl_if.sv
// Power-manager / cluster-status bundle for the clock-gate sequencer.
// master = power manager and cluster side, slave = the sequencer.
interface cluster_clock_gate_ctrl_if #(
    parameter int CNT_WIDTH = cluster_cg_pkg::CG_CNT_WIDTH
);
    logic                 test_mode_i;
    logic                 cg_req_i;
    logic                 cg_ack_o;
    logic                 busy_i;
    logic                 wake_evt_i;
    logic [CNT_WIDTH-1:0] quiesce_cfg_i;
    logic                 clk_en_o;
    logic [2:0]           state_o;

    modport master (
        output test_mode_i, cg_req_i, busy_i, wake_evt_i, quiesce_cfg_i,
        input  cg_ack_o, clk_en_o, state_o
    );

    modport slave (
        input  test_mode_i, cg_req_i, busy_i, wake_evt_i, quiesce_cfg_i,
        output cg_ack_o, clk_en_o, state_o
    );
endinterface

// File: rtl/cluster_clock_gate_ctrl.sv
// Cluster clock-gate sequencer: 4-phase req/ack, drain, quiesce countdown, gate, wake settle.
// Gate at k+2+N after req at edge k; release ack after WAKE_CYCLES; runs on the ungated clock.
module cluster_clock_gate_ctrl
    import cluster_cg_pkg::*;
#(
    parameter int CNT_WIDTH   = CG_CNT_WIDTH,
    parameter int WAKE_CYCLES = CG_WAKE_CYCLES
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    cluster_clock_gate_ctrl_if.slave    cg
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] WAKE_LOAD = CNT_WIDTH'(WAKE_CYCLES);

    cg_state_e            state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 wblk_q, wblk_d;
    logic                 clk_en_q;
    logic                 ack_q;

    always_comb begin
        state_d = ST_RUN;
        cnt_d   = cnt_q;
        wblk_d  = wblk_q;

        // Counter only runs in the two timed states and never wraps below zero.
        if ((state_q == ST_QUIESCE || state_q == ST_WAKE) && cnt_q != '0) begin
            cnt_d = cnt_q - CNT_ONE;
        end

        case (state_q)
            ST_RUN: begin
                if (cg.cg_req_i && !cg.wake_evt_i && !wblk_q) state_d = ST_DRAIN;
                else                                          state_d = ST_RUN;
            end
            ST_DRAIN: begin
                if (!cg.cg_req_i) begin
                    state_d = ST_RUN;
                end else if (!cg.busy_i) begin
                    if (cg.quiesce_cfg_i == '0) begin
                        state_d = ST_GATED;
                    end else begin
                        state_d = ST_QUIESCE;
                        cnt_d   = cg.quiesce_cfg_i;
                    end
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_QUIESCE: begin
                if (!cg.cg_req_i || cg.wake_evt_i) state_d = ST_RUN;
                else if (cg.busy_i)                state_d = ST_DRAIN;
                else if (cnt_q == CNT_ONE)         state_d = ST_GATED;
                else                               state_d = ST_QUIESCE;
            end
            ST_GATED: begin
                if (!cg.cg_req_i || cg.wake_evt_i) begin
                    state_d = ST_WAKE;
                    cnt_d   = WAKE_LOAD;
                end else begin
                    state_d = ST_GATED;
                end
            end
            ST_WAKE: begin
                if (cnt_q == CNT_ONE) state_d = ST_RUN;
                else                  state_d = ST_WAKE;
            end
            default: state_d = ST_RUN;
        endcase

        // An event wake under a live request must not immediately re-gate.
        if (!cg.cg_req_i) begin
            wblk_d = 1'b0;
        end else if (state_q == ST_GATED && cg.wake_evt_i) begin
            wblk_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_RUN;
            cnt_q    <= '0;
            wblk_q   <= 1'b0;
            clk_en_q <= 1'b1;
            ack_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wblk_q   <= wblk_d;
            clk_en_q <= st_clk_en(state_d);
            ack_q    <= st_ack(state_d);
        end
    end

    // Test mode overrides the enable without disturbing the sequencer.
    assign cg.clk_en_o = clk_en_q | cg.test_mode_i;
    assign cg.cg_ack_o = ack_q;
    assign cg.state_o  = state_q;

endmodule

// File: doc/cluster_clock_gate_ctrl.md
Name: cluster_clock_gate_ctrl

Overview:
- Sequences the cluster clock gate. The gate is the enable cell that sits ahead of the cluster clock inverter/buffer tree.
- Uses a 4-phase req/ack handshake with the power manager. It drains cluster activity, waits a programmable quiesce interval, then drops the clock enable.
- It restores the clock on request release or on a wake event.
- Runs on the free-running, ungated clock. It never drives its own clock.

Parameters:
- CNT_WIDTH, 8: width of the quiesce counter and of the quiesce configuration.
- WAKE_CYCLES, 2: cycles to hold in WAKE after re-enabling the clock, before the ack drops. Legal range 1..255.

Ports:
- clk_i  in  1  free-running clock, upstream of the gate.
- rst_i  in  1  reset; synchronous, active-high.
- test_mode_i  in  1  DFT override; forces the clock enabled.
- cg_req_i  in  1  power-manager request to gate the cluster clock.
- cg_ack_o  out  1  high while the clock is gated or in the wake settle window.
- busy_i  in  1  cluster activity (any core/DMA/interconnect busy).
- wake_evt_i  in  1  event-unit wake pulse or level.
- quiesce_cfg_i  in  CNT_WIDTH  idle cycles required after busy_i falls.
- clk_en_o  out  1  enable to the clock gate cell.
- state_o  out  3  encoded FSM state, for debug.

Behaviour:
- Reset values: state RUN, clk_en_o=1, cg_ack_o=0, counter=0, wake_block=0.
- Moore outputs decoded from registered state, with one exception: clk_en_o = clk_en_q | test_mode_i, combinational OR. The FSM keeps running in test mode.
- RUN
  - clk_en=1, ack=0.
  - Goes to DRAIN when cg_req_i=1, wake_evt_i=0 and wake_block=0.
- DRAIN
  - clk_en=1, ack=0.
  - cg_req_i=0 → RUN (abort).
  - Else busy_i=0 → QUIESCE, with counter loaded from quiesce_cfg_i.
  - If quiesce_cfg_i=0, go directly to GATED instead.
- QUIESCE
  - clk_en=1, ack=0. Counter decrements each cycle.
  - Priority order: cg_req_i=0 → RUN; then wake_evt_i=1 → RUN; then busy_i=1 → DRAIN; then counter==1 → GATED.
- GATED
  - clk_en=0, ack=1.
  - cg_req_i=0 or wake_evt_i=1 → WAKE, with counter loaded to WAKE_CYCLES.
  - A wake_evt_i arriving while cg_req_i is still high sets wake_block.
- WAKE
  - clk_en=1, ack=1. Counter decrements.
  - counter==1 → RUN, and ack falls on entry to RUN.
  - Requests are ignored while in WAKE.
- Latency: cg_req_i sampled high at edge k with busy_i low and quiesce_cfg_i=N≥1:
  - DRAIN at k+1, QUIESCE at k+2, GATED at k+2+N.
  - clk_en_o falls and cg_ack_o rises in the same cycle.
  - With N=0, GATED is reached at k+2.
- Release latency: cg_req_i low at edge g → WAKE at g+1 (clock on) → RUN at g+1+WAKE_CYCLES (ack low).
- wake_block
  - Cleared when cg_req_i=0.
  - Prevents immediate re-gating after an event wake.
  - The power manager sees ack fall while req is still high; this means the gate was aborted by an event.
- quiesce_cfg_i is sampled only at the counter load. Later changes do not affect a countdown already in progress.
- Counter is CNT_WIDTH bits, with no wrap: it loads, then decrements to 1 and exits. Value 0 is never decremented.
- Synchronous reset mid-operation, in any state: next cycle is RUN with clk_en=1 and ack=0.
- Illegal state encodings → RUN.
- state_o encoding: RUN=0, DRAIN=1, QUIESCE=2, GATED=3, WAKE=4.

Decomposition:
- Package cluster_cg_pkg holds:
  - the state enum typedef, 3-bit, with the encodings above;
  - the default constants for CNT_WIDTH and WAKE_CYCLES.
- No sub-module. The counter and FSM stay inline, at roughly 150 lines.
- The clock gate cell itself is instantiated by the parent, not inside this block.

Test Plan:
- Basic gate and release. quiesce_cfg_i=4, busy_i=0, req rises at cycle 0.
  - clk_en_o=0 and ack=1 from cycle 6.
  - Req drops at cycle 10: clk_en_o=1 at cycle 11, ack=0 at cycle 13.
- Drain and busy restart. quiesce_cfg_i=3, busy_i=1 for cycles 0–5 with req held high.
  - Stays in DRAIN, then QUIESCE from cycle 7.
  - Pulse busy_i at cycle 8: state returns to DRAIN, then GATED at 3 cycles after the next QUIESCE entry.
- Abort. Req rises at cycle 0 and falls at cycle 2, during QUIESCE with quiesce_cfg_i=5.
  - Returns to RUN at cycle 3. ack never rises; clk_en_o never falls.
- Event wake. In GATED, pulse wake_evt_i with req still high.
  - WAKE next cycle; RUN after 2 cycles with ack=0.
  - Stays in RUN while req is high, because wake_block is set.
  - Dropping req, then raising it again, re-gates.
- Zero quiesce and test mode. quiesce_cfg_i=0: GATED at cycle 2 after req.
  - With test_mode_i=1: clk_en_o stays 1 throughout, while state_o=3 and ack=1.
- Reset mid-gate. Assert rst_i for 1 cycle while GATED.
  - Next cycle: state_o=0, clk_en_o=1, cg_ack_o=0.
  - With req held high and busy_i=0, re-gating proceeds normally afterwards.
